// File: rtl/img_h_coord_table.sv
// img_h_coord_table: builds the per-output-line source row coordinate table for the vertical scaler
// and serves single-cycle-latency reads from it.
module img_h_coord_table #(
    parameter int DST_LINES  = 1080,
    parameter bit AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  cfg_src_h,
    input  logic [10:0] cfg_dst_h,
    input  logic        cfg_start,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    input  logic [10:0] h_ram_addr,
    input  logic        h_ram_rd,
    output logic        h_ram_data_vld,
    output logic        img_h_vld,
    output logic [14:0] img_h_data
);
    typedef enum logic [1:0] {IDLE, DIV, FILL, DONE} state_t;
    state_t state, state_nx;
    logic auto_pend, start_req, cfg_bad, accept;
    logic [9:0] src_l, lim;
    logic [10:0] dst_l, wr_addr;
    logic [10:0] rem;
    logic [11:0] trial;
    logic ge;
    logic [25:0] quo, q_next;
    logic [4:0] div_cnt;
    logic signed [37:0] acc;
    logic [14:0] clamp_hi;
    logic [15:0] wr_word, rd_word;
    logic [15:0] mem [DST_LINES];
    logic table_ok, rd_ok;

    assign start_req = cfg_start | auto_pend;
    assign cfg_bad   = cfg_src_h == '0 || cfg_dst_h == '0 || cfg_dst_h > 11'(DST_LINES);
    assign accept    = state == IDLE && start_req && !cfg_bad;
    assign busy      = state == DIV || state == FILL;
    assign done      = state == DONE;
    assign img_h_vld  = rd_ok & rd_word[15];
    assign img_h_data = rd_ok ? rd_word[14:0] : '0;

    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;

    always_comb begin
        state_nx = state == IDLE ? (accept ? DIV : IDLE)
                 : state == DIV  ? (div_cnt == 5'd25 ? FILL : DIV)
                 : state == FILL ? (wr_addr == 11'(DST_LINES - 1) ? DONE : FILL)
                 : IDLE;
        trial  = {rem, quo[25]};
        ge     = trial >= {1'b0, dst_l};
        q_next = {quo[24:0], ge};
        lim    = src_l - 10'd1;
        // clamp to [0, (src_h-1) << 16] and keep {int, 5 frac bits}, truncating
        clamp_hi = acc < 0 ? '0
                 : acc > $signed({12'b0, lim, 16'b0}) ? {lim, 5'b0}
                 : acc[25:11];
        wr_word = wr_addr < dst_l ? {1'b1, clamp_hi} : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_pend      <= AUTO_START;
            cfg_err        <= 1'b0;
            table_ok       <= 1'b0;
            h_ram_data_vld <= 1'b0;
            rd_ok          <= 1'b0;
        end else begin
            auto_pend      <= 1'b0;
            h_ram_data_vld <= h_ram_rd;
            if (state == IDLE && start_req)
                cfg_err <= cfg_bad;
            if (accept)
                table_ok <= 1'b0;
            else if (state == DONE)
                table_ok <= 1'b1;
            if (h_ram_rd)
                rd_ok <= table_ok;
        end
    end

    // quo starts as the dividend and shifts quotient bits in, ending as the step
    always_ff @(posedge clk) begin
        if (accept) begin
            src_l   <= cfg_src_h;
            dst_l   <= cfg_dst_h;
            rem     <= '0;
            quo     <= {cfg_src_h, 16'b0};
            div_cnt <= '0;
        end else if (state == DIV) begin
            rem     <= 11'(ge ? trial - {1'b0, dst_l} : trial);
            quo     <= q_next;
            div_cnt <= div_cnt + 5'd1;
            wr_addr <= '0;
            acc     <= 38'({1'b0, q_next[25:1]}) - 38'd32768;
        end else if (state == FILL) begin
            acc     <= acc + $signed({12'b0, quo});
            wr_addr <= wr_addr + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL)
            mem[wr_addr] <= wr_word;
        if (h_ram_rd)
            rd_word <= mem[h_ram_addr];
    end
endmodule
